fpu_mul_mantissa_core: RTL
==========================

Name: fpu_mul_mantissa_core

Overview:
- Iterative FP32 multiply front-end that sits directly upstream of the multiplier normaliser.
- Unpacks two IEEE-754 single operands, forms the biased exponent sum and the 24x24 mantissa product, and pre-adjusts product overflow.
- Presents {sign, exponent, 48-bit product, special flags} to the combinational normaliser.
- Uses a radix-2 shift-add datapath with valid/ready handshakes on both sides.

Parameters:
- MW, 24, mantissa width including hidden bit
- EW, 8, exponent field width
- BIAS, 127, exponent bias

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operands valid
- in_ready  out  1  core can accept operands
- in_a  in  32  operand A, IEEE single
- in_b  in  32  operand B, IEEE single
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_s  out  1  result sign
- out_e  out  EW  biased result exponent, to normaliser in_e
- out_m  out  2*MW  product mantissa, to normaliser in_m
- out_zero  out  1  result is zero
- out_inf  out  1  result is infinity
- out_nan  out  1  result is NaN
- out_ovf  out  1  exponent overflow
- out_unf  out  1  exponent underflow

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, in_ready=1.
  - out_valid, out_s, out_e, out_m and all flags = 0.
  - Accumulator, multiplicand, multiplier and counter cleared.
  - A reset during MUL or ADJ aborts the operation; no output is produced.
- States: IDLE, MUL, ADJ, DONE. in_ready=1 only in IDLE.
- IDLE: an edge with in_valid&&in_ready captures operands and moves to MUL with count=0.
  - sign = a[31]^b[31].
  - Hidden bit = 1 if the exponent field is nonzero.
  - Exponent field 0 (zero or denormal) is flushed to zero and sets the zero class.
  - Signed exponent: exp = ea+eb-BIAS, 10 bits wide.
- MUL: one multiplier bit per edge, LSB first.
  - If the multiplier LSB is set, acc += multiplicand<<count.
  - Then shift the multiplier right and increment count.
  - After MW (24) edges, go to ADJ.
- ADJ:
  - If product[47]=1: out_m=product>>1 and exp+=1. Otherwise out_m=product. Guarantees out_m[47]=0.
  - Saturate the exponent:
    - exp>=255: out_e=0xFF, out_ovf=1.
    - exp<=0: out_e=0x00, out_unf=1.
    - Otherwise out_e=exp[7:0].
  - Special-value precedence: NaN > inf > zero.
    - NaN: any operand NaN, or inf×zero.
    - Inf: any operand inf.
    - Zero: any operand zero/denormal.
    - On NaN, inf or zero, out_m=0 and out_ovf=out_unf=0. NaN/inf: out_e=0xFF. Zero: out_e=0.
  - Go to DONE with out_valid=1.
- Latency is fixed at 25 edges, accept-to-out_valid, regardless of operand class.
- DONE: outputs are held stable while out_valid&&!out_ready.
  - The edge with out_ready=1 clears out_valid and returns to IDLE; in_ready is high the following cycle.
  - Throughput is one operation per 27 cycles minimum.
- in_valid while busy is ignored; the operands are not latched.
- out_ready is don't-care outside DONE.

Test Plan:
- 1.5×2.0 (0x3FC00000, 0x40000000) -> after 25 edges: out_s=0, out_e=0x80, out_m=0x6000_0000_0000, all flags 0.
- 1.5×1.5 (0x3FC00000, 0x3FC00000) -> raw product 0x9000_0000_0000 is adjusted: out_m=0x4800_0000_0000, out_e=0x80.
- -0×1.0 (0x80000000, 0x3F800000) -> out_zero=1, out_s=1, out_e=0, out_m=0. Inf×0 (0x7F800000, 0) -> out_nan=1, out_e=0xFF.
- 0x7F000000×0x7F000000 -> out_ovf=1, out_e=0xFF. 0x00800000×0x00800000 -> out_unf=1, out_e=0.
- Handshake:
  - Hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0.
  - Pulse in_valid during MUL -> ignored.
  - out_ready=1 -> in_ready=1 next cycle; back-to-back pair completes correctly.
- Assert rst at MUL count 10 -> all outputs 0 immediately, in_ready=1. A new operation after release gives correct results.

Source files
------------

// File: rtl/fpu_mul_mantissa_core.sv
// Iterative FP32 multiply front-end: unpacks operands, forms the biased exponent sum
// and the 24x24 mantissa product (radix-2 shift-add), pre-adjusts product overflow.
module fpu_mul_mantissa_core #(
   parameter int unsigned MW   = 24,
   parameter int unsigned EW   = 8,
   parameter int unsigned BIAS = 127
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_a,
   input  logic [31:0]     in_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_s,
   output logic [EW-1:0]   out_e,
   output logic [2*MW-1:0] out_m,
   output logic            out_zero,
   output logic            out_inf,
   output logic            out_nan,
   output logic            out_ovf,
   output logic            out_unf
);

   localparam int unsigned PW = 2 * MW;
   localparam int unsigned XW = EW + 2;
   localparam int unsigned FW = MW - 1;
   localparam int unsigned CW = $clog2(MW + 1);
   localparam logic [XW-1:0] EMAX = XW'(2 ** EW - 1);

   typedef enum logic [1:0] {IDLE, MUL, ADJ, DONE} state_t;

   state_t state, state_next;

   logic [PW-1:0] acc;
   logic [MW-1:0] mcand;
   logic [MW-1:0] mplier;
   logic [CW-1:0] count;
   logic [XW-1:0] exp_r;
   logic          sign_r, nan_r, inf_r, zero_r;

   // Operand unpack and classification
   logic [EW-1:0] ea, eb;
   logic [FW-1:0] fa, fb;
   logic          a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic [XW-1:0] exp_in;

   assign ea     = in_a[FW +: EW];
   assign eb     = in_b[FW +: EW];
   assign fa     = in_a[FW-1:0];
   assign fb     = in_b[FW-1:0];
   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);
   assign a_nan  = (&ea) && (|fa);
   assign b_nan  = (&eb) && (|fb);
   assign a_inf  = (&ea) && !(|fa);
   assign b_inf  = (&eb) && !(|fb);
   assign exp_in = XW'(ea) + XW'(eb) - XW'(BIAS);

   // Product overflow pre-adjust and exponent range detection (exp is two's complement)
   logic [PW-1:0] prod_adj;
   logic [XW-1:0] exp_adj;
   logic          exp_ovf, exp_unf;

   always_comb begin
      prod_adj = acc;
      exp_adj  = exp_r;
      if (acc[PW-1]) begin
         prod_adj = acc >> 1;
         exp_adj  = exp_r + XW'(1);
      end
      exp_ovf = !exp_adj[XW-1] && (exp_adj >= EMAX);
      exp_unf = exp_adj[XW-1] || (exp_adj == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (in_valid) state_next = MUL;
         MUL:  if (count == CW'(MW - 1)) state_next = ADJ;
         ADJ:  state_next = DONE;
         DONE: if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_ready  <= 1'b1;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         count     <= '0;
         exp_r     <= '0;
         sign_r    <= 1'b0;
         nan_r     <= 1'b0;
         inf_r     <= 1'b0;
         zero_r    <= 1'b0;
         out_valid <= 1'b0;
         out_s     <= 1'b0;
         out_e     <= '0;
         out_m     <= '0;
         out_zero  <= 1'b0;
         out_inf   <= 1'b0;
         out_nan   <= 1'b0;
         out_ovf   <= 1'b0;
         out_unf   <= 1'b0;
      end else begin
         in_ready <= (state_next == IDLE);
         case (state)
            IDLE: if (in_valid) begin
               sign_r <= in_a[FW+EW] ^ in_b[FW+EW];
               exp_r  <= exp_in;
               nan_r  <= a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
               inf_r  <= a_inf || b_inf;
               zero_r <= a_zero || b_zero;
               mcand  <= a_zero ? '0 : {1'b1, fa};
               mplier <= b_zero ? '0 : {1'b1, fb};
               acc    <= '0;
               count  <= '0;
            end
            MUL: begin
               if (mplier[0]) acc <= acc + (PW'(mcand) << count);
               mplier <= mplier >> 1;
               count  <= count + CW'(1);
            end
            ADJ: begin
               out_valid <= 1'b1;
               out_s     <= sign_r;
               out_nan   <= nan_r;
               out_inf   <= inf_r && !nan_r;
               out_zero  <= zero_r && !nan_r && !inf_r;
               if (nan_r || inf_r) begin
                  out_e   <= '1;
                  out_m   <= '0;
                  out_ovf <= 1'b0;
                  out_unf <= 1'b0;
               end else if (zero_r) begin
                  out_e   <= '0;
                  out_m   <= '0;
                  out_ovf <= 1'b0;
                  out_unf <= 1'b0;
               end else begin
                  out_m   <= prod_adj;
                  out_ovf <= exp_ovf;
                  out_unf <= exp_unf;
                  out_e   <= exp_ovf ? '1 : (exp_unf ? '0 : exp_adj[EW-1:0]);
               end
            end
            DONE: if (out_ready) out_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule
